// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: next-PC controls, instruction-memory req/ack bus and decode valid/ready bus
interface pc_fetch_unit_if;
    logic [2:0]  pcsel;
    logic [15:0] literal;
    logic [31:0] jt;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    modport master (
        input  pcsel, literal, jt, imem_ack, imem_rdata, instr_ready,
        output imem_req, imem_addr, instr, instr_valid, pc, pc_plus4
    );
    modport slave (
        output pcsel, literal, jt, imem_ack, imem_rdata, instr_ready,
        input  imem_req, imem_addr, instr, instr_valid, pc, pc_plus4
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter plus single-outstanding instruction fetch feeding the control unit
module pc_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h8000_0000,
    parameter logic [31:0] ILLOP_VECTOR = 32'h8000_0004,
    parameter logic [31:0] XADR_VECTOR  = 32'h8000_0008
) (
    input  logic              clk,
    input  logic              reset,
    pc_fetch_unit_if.master   bus
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, r_instr, w_pc_plus4, w_branch, w_next_pc;
    logic        r_valid, w_fetch_done, w_accept;
    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_branch   = w_pc_plus4 + {{14{bus.literal[15]}}, bus.literal, 2'b00};
    // branches keep the supervisor bit; jumps may only clear it
    always_comb begin
        case (bus.pcsel)
            3'd0:    w_next_pc = {w_pc_plus4[31:2], 2'b00};
            3'd1:    w_next_pc = {r_pc[31], w_branch[30:2], 2'b00};
            3'd2:    w_next_pc = {r_pc[31] & bus.jt[31], bus.jt[30:2], 2'b00};
            3'd4:    w_next_pc = XADR_VECTOR;
            default: w_next_pc = ILLOP_VECTOR;
        endcase
    end
    always_comb begin
        w_state_nxt  = r_state;
        w_fetch_done = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            IDLE:    w_state_nxt = FETCH;
            FETCH: begin
                w_fetch_done = bus.imem_ack;
                w_state_nxt  = bus.imem_ack ? HOLD : FETCH;
            end
            HOLD: begin
                w_accept    = r_valid & bus.instr_ready;
                w_state_nxt = (r_valid & bus.instr_ready) ? FETCH : HOLD;
            end
            default: w_state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_pc    <= RESET_VECTOR;
            r_instr <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_fetch_done) begin
                r_instr <= bus.imem_rdata;
                r_valid <= 1'b1;
            end
            if (w_accept) begin
                r_valid <= 1'b0;
                r_pc    <= w_next_pc;
            end
        end
    end
    assign bus.imem_req    = (r_state == FETCH);
    assign bus.imem_addr   = r_pc;
    assign bus.instr       = r_instr;
    assign bus.instr_valid = r_valid;
    assign bus.pc          = r_pc;
    assign bus.pc_plus4    = w_pc_plus4;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed fetch/accept sequence with address and instruction scoreboards
module tb_pc_fetch_unit;
    localparam logic [31:0] RESET_VECTOR = 32'h8000_0000;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] addr_q[$];
    logic [31:0] instr_q[$];
    logic [31:0] cur_pc;
    pc_fetch_unit_if bus();
    pc_fetch_unit dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic serve(input logic [31:0] data, input int delay);
        int n = 0;
        logic [31:0] a;
        while (bus.imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", 32'(bus.imem_req), 32'd1);
        a = addr_q.pop_front();
        cur_pc = a;
        chk("imem_addr", bus.imem_addr, a);
        chk("pc", bus.pc, a);
        chk("pc_plus4", bus.pc_plus4, a + 32'd4);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            chk("addr_stable", bus.imem_addr, a);
            chk("valid_during_fetch", 32'(bus.instr_valid), 32'd0);
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = data;
        instr_q.push_back(data);
        @(negedge clk);
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        chk("valid_rise", 32'(bus.instr_valid), 32'd1);
        chk("req_drop", 32'(bus.imem_req), 32'd0);
    endtask
    task automatic take(input logic [2:0] sel, input logic [15:0] lit, input logic [31:0] jtv,
                        input int hold, input logic [31:0] nxt);
        int n = 0;
        logic [31:0] e;
        while (bus.instr_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("valid_seen", 32'(bus.instr_valid), 32'd1);
        e = instr_q.pop_front();
        chk("instr", bus.instr, e);
        if (hold > 0) begin
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = 32'hDEAD_BEEF;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("instr_hold", bus.instr, e);
            chk("valid_hold", 32'(bus.instr_valid), 32'd1);
            chk("no_req_in_hold", 32'(bus.imem_req), 32'd0);
            chk("pc_hold", bus.pc, cur_pc);
        end
        bus.imem_ack    = 1'b0;
        bus.pcsel       = sel;
        bus.literal     = lit;
        bus.jt          = jtv;
        bus.instr_ready = 1'b1;
        @(negedge clk);
        bus.instr_ready = 1'b0;
        bus.pcsel       = 3'd7;
        bus.literal     = 16'h5A5A;
        bus.jt          = 32'hFFFF_FFFF;
        chk("valid_clear", 32'(bus.instr_valid), 32'd0);
        addr_q.push_back(nxt);
    endtask
    initial begin
        bus.pcsel       = '0;
        bus.literal     = '0;
        bus.jt          = '0;
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = '0;
        bus.instr_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_instr", bus.instr, 32'd0);
        chk("rst_pc", bus.pc, RESET_VECTOR);
        reset = 1'b0;
        addr_q.push_back(RESET_VECTOR);
        @(negedge clk);
        chk("req_after_reset", 32'(bus.imem_req), 32'd1);
        serve(32'h8022_0800, 0);
        take(3'd0, 16'h0000, 32'h0, 0, 32'h8000_0004);
        serve(32'h0000_0001, 0);
        take(3'd1, 16'h0002, 32'h0, 0, 32'h8000_0010);
        serve(32'h0000_0002, 0);
        take(3'd1, 16'hFFFE, 32'h0, 0, 32'h8000_000C);
        serve(32'h0000_0003, 0);
        take(3'd0, 16'h0000, 32'h0, 0, 32'h8000_0010);
        serve(32'h0000_0004, 0);
        take(3'd1, 16'h0003, 32'h0, 0, 32'h8000_0020);
        serve(32'h0000_0005, 0);
        take(3'd2, 16'h0000, 32'h8000_0040, 0, 32'h8000_0040);
        serve(32'h0000_0006, 0);
        take(3'd2, 16'h0000, 32'h0000_0103, 0, 32'h0000_0100);
        serve(32'h0000_0007, 0);
        take(3'd2, 16'h0000, 32'h8000_0000, 0, 32'h0000_0000);
        serve(32'h0000_0008, 0);
        take(3'd2, 16'h0000, 32'hFFFF_FFFC, 0, 32'h7FFF_FFFC);
        serve(32'h0000_0009, 0);
        take(3'd1, 16'h0000, 32'h0, 0, 32'h0000_0000);
        serve(32'h0000_000A, 0);
        take(3'd3, 16'h0000, 32'h0, 0, 32'h8000_0004);
        serve(32'h0000_000B, 0);
        take(3'd4, 16'h0000, 32'h0, 0, 32'h8000_0008);
        serve(32'h0000_000C, 0);
        take(3'd6, 16'h0000, 32'h0, 0, 32'h8000_0004);
        serve(32'h0000_000D, 0);
        take(3'd2, 16'h0000, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFC);
        serve(32'h0000_000E, 0);
        take(3'd0, 16'h0000, 32'h0, 0, 32'h0000_0000);
        serve(32'hA5A5_0F0F, 5);
        take(3'd0, 16'h0000, 32'h0, 4, 32'h0000_0004);
        chk("req_before_reset", 32'(bus.imem_req), 32'd1);
        reset          = 1'b1;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h1234_5678;
        @(negedge clk);
        reset          = 1'b0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        chk("ack_in_reset_valid", 32'(bus.instr_valid), 32'd0);
        chk("ack_in_reset_req", 32'(bus.imem_req), 32'd0);
        chk("ack_in_reset_instr", bus.instr, 32'd0);
        chk("ack_in_reset_pc", bus.pc, RESET_VECTOR);
        addr_q.delete();
        addr_q.push_back(RESET_VECTOR);
        serve(32'hCAFE_0001, 0);
        take(3'd0, 16'h0000, 32'h0, 0, 32'h8000_0004);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
